// File: rtl/cavlc_state_controller.sv
// cavlc_state_controller: steps one CAVLC residual block through coeff_token, trailing-ones
// signs, level prefix/suffix, total_zeros and run_before, then pulses cavlc_end.
// Latency: one state per cycle when bs_ready is high; Done lasts exactly one cycle.
// Backpressure: every decoding state and all counters hold while bs_ready is low.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   cavlc_start           one-cycle pulse, accepted only in Idle
//   bs_ready              bitstream buffer has >= 16 valid bits
//   TotalCoeff[4:0]       coeff_token result, latched when leaving NumCoeffTrailingOnes_LUT
//   TrailingOnes[1:0]     coeff_token result, sampled in the same cycle as TotalCoeff
//   maxNumCoeff[4:0]      block size, latched on cavlc_start
//   levelSuffixSize[3:0]  suffix length of the current level
//   total_zeros[3:0]      total_zeros LUT output
//   run_before[3:0]       run_before LUT output
//   cavlc_decoder_state   current state code (0..7)
//   i_level, zerosLeft    coefficient index and remaining zeros
//   cavlc_busy            registered, high whenever the state is not Idle
//   cavlc_end             registered, high during the Done cycle only
//   run_err               sticky run_before overflow flag, cleared on cavlc_start

module cavlc_state_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cavlc_start,
  input  logic       bs_ready,
  input  logic [4:0] TotalCoeff,
  input  logic [1:0] TrailingOnes,
  input  logic [4:0] maxNumCoeff,
  input  logic [3:0] levelSuffixSize,
  input  logic [3:0] total_zeros,
  input  logic [3:0] run_before,
  output logic [3:0] cavlc_decoder_state,
  output logic [3:0] i_level,
  output logic [3:0] zerosLeft,
  output logic       cavlc_busy,
  output logic       cavlc_end,
  output logic       run_err
);

  localparam logic [3:0] S_IDLE        = 4'd0;
  localparam logic [3:0] S_COEFF_TOKEN = 4'd1;
  localparam logic [3:0] S_T1_SIGN     = 4'd2;
  localparam logic [3:0] S_LVL_PREFIX  = 4'd3;
  localparam logic [3:0] S_LVL_SUFFIX  = 4'd4;
  localparam logic [3:0] S_TOTAL_ZEROS = 4'd5;
  localparam logic [3:0] S_RUN_BEFORE  = 4'd6;
  localparam logic [3:0] S_DONE        = 4'd7;

  // State and counters
  logic [3:0] r_state;
  logic [3:0] r_i_level;
  logic [3:0] r_zeros_left;
  logic [4:0] r_total_coeff;
  logic [4:0] r_max_num_coeff;
  logic       r_busy;
  logic       r_end;
  logic       r_run_err;

  // Next-state values
  logic [3:0] w_state_nxt;
  logic [3:0] w_i_level_nxt;
  logic [3:0] w_zeros_left_nxt;
  logic [4:0] w_total_coeff_nxt;
  logic [4:0] w_max_num_coeff_nxt;
  logic       w_run_err_nxt;

  // Arithmetic helpers
  logic [4:0] w_il_inc;       // i_level+1 kept 5 bits wide so 15+1 compares as 16
  logic [3:0] w_il_sat;       // i_level+1 saturated at 15 for storage
  logic [3:0] w_zl_sub;
  logic       w_rb_over;
  logic [3:0] w_post_state;   // post-level decision using the latched TotalCoeff
  logic [3:0] w_after_level;  // where to go once a level has been completed

  assign w_il_inc  = {1'b0, r_i_level} + 5'd1;
  assign w_il_sat  = (r_i_level == 4'hF) ? 4'hF : (r_i_level + 4'd1);
  assign w_rb_over = (run_before > r_zeros_left);
  assign w_zl_sub  = r_zeros_left - run_before;

  // A full block (TotalCoeff == maxNumCoeff) has no zeros to place.
  assign w_post_state  = (r_total_coeff < r_max_num_coeff) ? S_TOTAL_ZEROS : S_DONE;
  assign w_after_level = (w_il_inc < r_total_coeff) ? S_LVL_PREFIX : w_post_state;

  always_comb begin
    w_state_nxt         = r_state;
    w_i_level_nxt       = r_i_level;
    w_zeros_left_nxt    = r_zeros_left;
    w_total_coeff_nxt   = r_total_coeff;
    w_max_num_coeff_nxt = r_max_num_coeff;
    w_run_err_nxt       = r_run_err;

    case (r_state)
      S_IDLE: begin
        if (cavlc_start) begin
          w_state_nxt         = S_COEFF_TOKEN;
          w_max_num_coeff_nxt = maxNumCoeff;
          w_run_err_nxt       = 1'b0;
        end
      end

      S_COEFF_TOKEN: begin
        if (bs_ready) begin
          // TotalCoeff is not latched yet, so decide on the live LUT outputs.
          w_total_coeff_nxt = TotalCoeff;
          w_i_level_nxt     = {2'b00, TrailingOnes};
          if (TotalCoeff == 5'd0) begin
            w_state_nxt = S_DONE;
          end else if (TrailingOnes != 2'd0) begin
            w_state_nxt = S_T1_SIGN;
          end else if (TotalCoeff > {3'b000, TrailingOnes}) begin
            w_state_nxt = S_LVL_PREFIX;
          end else if (TotalCoeff < r_max_num_coeff) begin
            w_state_nxt = S_TOTAL_ZEROS;
          end else begin
            w_state_nxt      = S_DONE;
            w_zeros_left_nxt = 4'd0;
          end
        end
      end

      S_T1_SIGN: begin
        if (bs_ready) begin
          if ({1'b0, r_i_level} < r_total_coeff) begin
            w_state_nxt = S_LVL_PREFIX;
          end else begin
            w_state_nxt = w_post_state;
            if (w_post_state == S_DONE) begin
              w_zeros_left_nxt = 4'd0;
            end
          end
        end
      end

      S_LVL_PREFIX: begin
        if (bs_ready) begin
          if (levelSuffixSize != 4'd0) begin
            w_state_nxt = S_LVL_SUFFIX;
          end else begin
            // No suffix: the prefix alone finishes this level.
            w_i_level_nxt = w_il_sat;
            w_state_nxt   = w_after_level;
            if (w_after_level == S_DONE) begin
              w_zeros_left_nxt = 4'd0;
            end
          end
        end
      end

      S_LVL_SUFFIX: begin
        if (bs_ready) begin
          w_i_level_nxt = w_il_sat;
          w_state_nxt   = w_after_level;
          if (w_after_level == S_DONE) begin
            w_zeros_left_nxt = 4'd0;
          end
        end
      end

      S_TOTAL_ZEROS: begin
        if (bs_ready) begin
          w_zeros_left_nxt = total_zeros;
          w_i_level_nxt    = 4'd0;
          if ((total_zeros != 4'd0) && (r_total_coeff > 5'd1)) begin
            w_state_nxt = S_RUN_BEFORE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_RUN_BEFORE: begin
        if (bs_ready) begin
          w_i_level_nxt = w_il_sat;
          if (w_rb_over) begin
            // Corrupt run: clamp, flag and terminate the block.
            w_zeros_left_nxt = 4'd0;
            w_run_err_nxt    = 1'b1;
            w_state_nxt      = S_DONE;
          end else begin
            w_zeros_left_nxt = w_zl_sub;
            // The last coefficient never carries a run_before.
            if ((w_zl_sub != 4'd0) && (w_il_inc < (r_total_coeff - 5'd1))) begin
              w_state_nxt = S_RUN_BEFORE;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_i_level       <= 4'd0;
      r_zeros_left    <= 4'd0;
      r_total_coeff   <= 5'd0;
      r_max_num_coeff <= 5'd0;
      r_busy          <= 1'b0;
      r_end           <= 1'b0;
      r_run_err       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_i_level       <= w_i_level_nxt;
      r_zeros_left    <= w_zeros_left_nxt;
      r_total_coeff   <= w_total_coeff_nxt;
      r_max_num_coeff <= w_max_num_coeff_nxt;
      r_run_err       <= w_run_err_nxt;
      // Flags registered from the next state so they line up with r_state.
      r_busy          <= (w_state_nxt != S_IDLE);
      r_end           <= (w_state_nxt == S_DONE);
    end
  end

  assign cavlc_decoder_state = r_state;
  assign i_level             = r_i_level;
  assign zerosLeft           = r_zeros_left;
  assign cavlc_busy          = r_busy;
  assign cavlc_end           = r_end;
  assign run_err             = r_run_err;

endmodule

// File: tb/tb_cavlc_state_controller.sv
// Testbench for cavlc_state_controller: a block-level reference model expands each block's
// parameters into the expected list of visited states; a monitor pops and compares them.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.

module tb_cavlc_state_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cavlc_start;
  logic       bs_ready;
  logic [4:0] TotalCoeff;
  logic [1:0] TrailingOnes;
  logic [4:0] maxNumCoeff;
  logic [3:0] levelSuffixSize;
  logic [3:0] total_zeros;
  logic [3:0] run_before;
  logic [3:0] cavlc_decoder_state;
  logic [3:0] i_level;
  logic [3:0] zerosLeft;
  logic       cavlc_busy;
  logic       cavlc_end;
  logic       run_err;

  typedef struct {
    int st;
    int il;
    int zl;
    int err;
  } step_t;

  step_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    m_il    = 0;
  int    m_zl    = 0;
  int    rb_tab[16];

  always #5 clk = ~clk;

  cavlc_state_controller dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cavlc_start         (cavlc_start),
    .bs_ready            (bs_ready),
    .TotalCoeff          (TotalCoeff),
    .TrailingOnes        (TrailingOnes),
    .maxNumCoeff         (maxNumCoeff),
    .levelSuffixSize     (levelSuffixSize),
    .total_zeros         (total_zeros),
    .run_before          (run_before),
    .cavlc_decoder_state (cavlc_decoder_state),
    .i_level             (i_level),
    .zerosLeft           (zerosLeft),
    .cavlc_busy          (cavlc_busy),
    .cavlc_end           (cavlc_end),
    .run_err             (run_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_step(input int st, input int il, input int zl, input int err);
    step_t s;
    s.st = st; s.il = il; s.zl = zl; s.err = err;
    exp_q.push_back(s);
  endtask

  // Expand one block into the states it must visit, with the i_level/zerosLeft/run_err
  // visible while in each state. rb_tab holds the run_before value for each run step.
  task automatic model_block(input int tc, input int t1, input int mx, input int lss, input int tz);
    int il, zl, err;
    il = m_il; zl = m_zl; err = 0;
    push_step(1, il, zl, err);
    il = t1;
    if (tc != 0) begin
      if (t1 > 0) push_step(2, il, zl, err);
      for (int lvl = t1; lvl < tc; lvl++) begin
        push_step(3, il, zl, err);
        if (lss != 0) push_step(4, il, zl, err);
        il = (lvl + 1 > 15) ? 15 : lvl + 1;
      end
      if (tc < mx) begin
        push_step(5, il, zl, err);
        zl = tz;
        il = 0;
        if (tz != 0 && tc > 1) begin
          for (int k = 0; k < 16; k++) begin
            push_step(6, il, zl, err);
            il = (il + 1 > 15) ? 15 : il + 1;
            if (rb_tab[k] > zl) begin
              zl = 0;
              err = 1;
              break;
            end
            zl = zl - rb_tab[k];
            if (zl == 0 || il >= tc - 1) break;
          end
        end
      end else begin
        zl = 0;
      end
    end
    push_step(7, il, zl, err);
    m_il = il;
    m_zl = zl;
  endtask

  // Monitor: every active cycle must match the head of the expected list; the head is
  // consumed when the DUT is allowed to advance (bs_ready high, or Done).
  initial begin
    step_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (cavlc_busy || cavlc_decoder_state != 4'd0) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_activity: state %0d busy %0d with nothing expected (t=%0t)",
                     cavlc_decoder_state, cavlc_busy, $time);
          end else begin
            e = exp_q[0];
            chk("state", int'(cavlc_decoder_state), e.st);
            chk("i_level", int'(i_level), e.il);
            chk("zerosLeft", int'(zerosLeft), e.zl);
            chk("run_err", int'(run_err), e.err);
            chk("cavlc_end", int'(cavlc_end), (e.st == 7) ? 1 : 0);
            chk("cavlc_busy", int'(cavlc_busy), 1);
            if (e.st == 7 || bs_ready) void'(exp_q.pop_front());
          end
        end else begin
          chk("idle_end", int'(cavlc_end), 0);
        end
      end
    end
  end

  task automatic mid_block_reset();
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    m_il = 0;
    m_zl = 0;
    #1;
    chk("abort_state", int'(cavlc_decoder_state), 0);
    chk("abort_i_level", int'(i_level), 0);
    chk("abort_zerosLeft", int'(zerosLeft), 0);
    chk("abort_busy", int'(cavlc_busy), 0);
    chk("abort_end", int'(cavlc_end), 0);
    chk("abort_run_err", int'(run_err), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n  = 1'b1;
    bs_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("post_abort_end", int'(cavlc_end), 0);
      chk("post_abort_state", int'(cavlc_decoder_state), 0);
      @(posedge clk); #1;
    end
  endtask

  // mode 0: bs_ready always high; 1: random; 2: three-cycle stall on first LevelSuffix.
  task automatic run_block(input int tc, input int t1, input int mx, input int lss, input int tz,
                           input int mode, input bit abort);
    int rb_idx, cyc, stall_left;
    bit adv, seen_ls, done;
    rb_idx = 0; cyc = 0; stall_left = 0; seen_ls = 1'b0; done = 1'b0;
    model_block(tc, t1, mx, lss, tz);
    TotalCoeff      = 5'(tc);
    TrailingOnes    = 2'(t1);
    maxNumCoeff     = 5'(mx);
    levelSuffixSize = 4'(lss);
    total_zeros     = 4'(tz);
    run_before      = 4'(rb_tab[0]);
    bs_ready        = 1'b1;
    cavlc_start     = 1'b1;
    @(posedge clk); #1;
    cavlc_start = 1'b0;
    while (!done && cyc < 300) begin
      if (abort && cavlc_decoder_state == 4'd6) begin
        mid_block_reset();
        return;
      end
      if (cavlc_end) done = 1'b1;
      if (mode == 2) begin
        if (cavlc_decoder_state == 4'd4 && !seen_ls) begin
          seen_ls    = 1'b1;
          stall_left = 3;
        end
        bs_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else if (mode == 1) begin
        bs_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bs_ready = 1'b1;
      end
      run_before = 4'(rb_tab[rb_idx]);
      adv = (cavlc_decoder_state == 4'd6) && bs_ready;
      @(posedge clk); #1;
      cyc++;
      if (adv && rb_idx < 15) rb_idx++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL block_timeout: state %0d after %0d cycles, expected a cavlc_end", cavlc_decoder_state, cyc);
      exp_q.delete();
    end
  endtask

  initial begin
    reset_n = 1'b1; cavlc_start = 1'b0; bs_ready = 1'b0;
    TotalCoeff = '0; TrailingOnes = '0; maxNumCoeff = 5'd16;
    levelSuffixSize = '0; total_zeros = '0; run_before = '0;
    for (int k = 0; k < 16; k++) rb_tab[k] = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset_state", int'(cavlc_decoder_state), 0);
    chk("reset_i_level", int'(i_level), 0);
    chk("reset_zerosLeft", int'(zerosLeft), 0);
    chk("reset_busy", int'(cavlc_busy), 0);
    chk("reset_end", int'(cavlc_end), 0);
    chk("reset_run_err", int'(run_err), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // No coefficients: 1 -> 7 -> 0.
    run_block(0, 0, 16, 0, 0, 0, 1'b0);
    // Mixed block with trailing ones, levels and two run_before steps.
    rb_tab[0] = 1; rb_tab[1] = 1;
    run_block(3, 1, 16, 0, 2, 0, 1'b0);
    // Full 16-coefficient block with suffixes and a 3-cycle stall in LevelSuffix.
    run_block(16, 3, 16, 2, 0, 2, 1'b0);
    // run_before larger than the zeros left.
    rb_tab[0] = 3;
    run_block(2, 0, 16, 0, 1, 0, 1'b0);
    // Next start clears run_err.
    run_block(0, 0, 4, 0, 0, 1, 1'b0);
    // Reset while in run_before_LUT.
    for (int k = 0; k < 16; k++) rb_tab[k] = 0;
    run_block(8, 0, 16, 0, 5, 0, 1'b1);

    for (int b = 0; b < 40; b++) begin
      int mx, tc, t1, lss, tz, sel;
      sel = $urandom_range(0, 2);
      mx  = (sel == 0) ? 4 : ((sel == 1) ? 15 : 16);
      tc  = $urandom_range(0, mx);
      t1  = (tc == 0) ? 0 : $urandom_range(0, (tc < 3) ? tc : 3);
      lss = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 15);
      tz  = $urandom_range(0, (mx - tc > 15) ? 15 : mx - tc);
      for (int k = 0; k < 16; k++)
        rb_tab[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      run_block(tc, t1, mx, lss, tz, 1, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cavlc_state_controller.md
CAVLC_STATE_CONTROLLER -- requirements
Module: cavlc_state_controller

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 The port list SHALL be:
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- cavlc_start  in  1  one-cycle pulse that starts one residual block.
- bs_ready  in  1  bitstream buffer holds at least 16 valid bits; FSM advances only when high.
- TotalCoeff  in  5  from coeff_token LUT, sampled at the end of NumCoeffTrailingOnes_LUT.
- TrailingOnes  in  2  from coeff_token LUT, sampled in the same cycle as TotalCoeff.
- maxNumCoeff  in  5  block size (4, 15 or 16), sampled on cavlc_start.
- levelSuffixSize  in  4  suffix length for the current level.
- total_zeros  in  4  from total_zeros LUT.
- run_before  in  4  from run_before LUT.
- cavlc_decoder_state  out  4  current state; drives the consumed-bits decoder.
- i_level  out  4  current coefficient index.
- zerosLeft  out  4  remaining zeros.
- cavlc_busy  out  1  high whenever the state is not Idle.
- cavlc_end  out  1  one-cycle pulse when the block is done.
- run_err  out  1  sticky flag, cleared on cavlc_start.

Function
REQ-003 State encoding SHALL be: Idle=0, NumCoeffTrailingOnes_LUT=1, TrailingOnesSignFlag=2, LevelPrefix=3, LevelSuffix=4, total_zeros_LUT=5, run_before_LUT=6, Done=7; codes 8-15 SHALL recover to Idle.
REQ-004 Every state except Idle and Done SHALL hold its value while bs_ready=0; all counters SHALL also hold.
REQ-005 In Idle with cavlc_start=1, the next state SHALL be NumCoeffTrailingOnes_LUT; cavlc_start SHALL be ignored in all other states.
REQ-006 Leaving NumCoeffTrailingOnes_LUT, the next state SHALL be chosen in this order:
- TotalCoeff=0: Done.
- TrailingOnes>0: TrailingOnesSignFlag.
- TotalCoeff>TrailingOnes: LevelPrefix.
- Otherwise: the REQ-009 decision.
REQ-007 Leaving NumCoeffTrailingOnes_LUT, i_level SHALL be loaded with TrailingOnes; TrailingOnesSignFlag SHALL last one cycle and then go to LevelPrefix if i_level<TotalCoeff, else to the REQ-009 decision.
REQ-008 LevelPrefix SHALL go to LevelSuffix if levelSuffixSize≠0.
- Otherwise it completes the level: i_level increments, then go to LevelPrefix if i_level+1<TotalCoeff, else to the REQ-009 decision.
- LevelSuffix SHALL complete the level the same way.
REQ-009 Post-level decision:
- TotalCoeff<maxNumCoeff: total_zeros_LUT.
- Otherwise: zerosLeft:=0 and go to Done.
REQ-010 total_zeros_LUT SHALL load zerosLeft:=total_zeros and clear i_level to 0.
- Next state: run_before_LUT if total_zeros≠0 and TotalCoeff>1, else Done.
REQ-011 Each run_before_LUT cycle SHALL do zerosLeft:=zerosLeft−run_before and i_level+1.
- It SHALL stay in run_before_LUT while the new zerosLeft≠0 and the new i_level<TotalCoeff−1; otherwise go to Done.
REQ-012 If run_before>zerosLeft, zerosLeft SHALL saturate to 0, run_err SHALL set, and the next state SHALL be Done.
REQ-013 Done SHALL last one cycle, assert cavlc_end in that cycle, and return to Idle.
REQ-014 cavlc_busy SHALL be a registered output equal to (state≠Idle).
REQ-015 All arithmetic SHALL be unsigned and 4 bits wide.
- TotalCoeff comparisons SHALL use 5 bits.
- i_level SHALL never exceed 15 and SHALL saturate at 15 rather than wrap.

Reset
REQ-016 When reset_n=0, within the same cycle:
- state SHALL be Idle.
- i_level, zerosLeft, cavlc_busy, cavlc_end and run_err SHALL be 0.
REQ-017 A reset asserted mid-block SHALL abort the block without producing cavlc_end.
REQ-018 After reset release, the block SHALL wait for a fresh cavlc_start.

Verification
REQ-019 TotalCoeff=0 → states 1,7,0 with bs_ready=1; cavlc_end asserts exactly once.
REQ-020 TotalCoeff=3, TrailingOnes=1, maxNumCoeff=16, levelSuffixSize=0, total_zeros=2, run_before=1,1 → states:
- 1, 2, 3, 3, 5, 6, 6, 7, 0.
- zerosLeft after 5: 2; zerosLeft after 6: 1, then 0.
REQ-021 TotalCoeff=16=maxNumCoeff, TrailingOnes=3, levelSuffixSize=2 → 13 LevelPrefix/LevelSuffix pairs, then Done with no total_zeros_LUT; i_level ends at 15.
REQ-022 Hold bs_ready=0 for 3 cycles in LevelSuffix → state and i_level stay frozen for those 3 cycles and the sequence then resumes unchanged.
REQ-023 zerosLeft=1 with run_before=3 → zerosLeft=0, run_err=1, next state is Done; a following cavlc_start clears run_err.
REQ-024 Assert reset_n=0 while in run_before_LUT → all outputs return to 0 immediately and no cavlc_end is produced.
